// File: rtl/rel_branch_resolve.sv
// Conditional branch resolver: waits for comparator flags, evaluates the condition code,
// and holds the resolved next PC until fetch accepts it. A timeout resolves as not-taken with out_err.
module rel_branch_resolve #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmp_valid,
  input  logic             cmp_res,
  input  logic             cmp_z,
  input  logic             cmp_n,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_cond,
  input  logic [WIDTH-1:0] br_pc,
  input  logic [WIDTH-1:0] br_off,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [WIDTH-1:0] out_target,
  output logic             out_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [7:0]       TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [WIDTH-1:0] PC_STEP     = WIDTH'(4);

  state_t           state_q, state_d;
  logic             r_q, r_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             flag_vld_q, flag_vld_d;
  logic [2:0]       cond_q, cond_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] off_q, off_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             out_taken_q, out_taken_d;
  logic [WIDTH-1:0] out_target_q, out_target_d;
  logic             out_err_q, out_err_d;

  logic             eff_r, eff_z, eff_n;
  logic [2:0]       sel_cond;
  logic [WIDTH-1:0] sel_pc, sel_off;
  logic             res_taken;
  logic [WIDTH-1:0] res_target;
  logic [7:0]       cnt_inc;

  function automatic logic cond_true(input logic [2:0] c, input logic r, input logic z,
                                     input logic n);
    logic t;
    unique case (c)
      3'b000:  t = 1'b1;
      3'b001:  t = r;
      3'b010:  t = !r;
      3'b011:  t = z;
      3'b100:  t = !z;
      3'b101:  t = n;
      3'b110:  t = !n;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // Same-cycle comparator flags take precedence over the stored copy.
  assign eff_r = cmp_valid ? cmp_res : r_q;
  assign eff_z = cmp_valid ? cmp_z   : z_q;
  assign eff_n = cmp_valid ? cmp_n   : n_q;

  // While idle the branch is resolved straight off the request ports, later from the captured copy.
  assign sel_cond   = (state_q == S_IDLE) ? br_cond : cond_q;
  assign sel_pc     = (state_q == S_IDLE) ? br_pc   : pc_q;
  assign sel_off    = (state_q == S_IDLE) ? br_off  : off_q;
  assign res_taken  = cond_true(sel_cond, eff_r, eff_z, eff_n);
  assign res_target = res_taken ? (sel_pc + sel_off) : (sel_pc + PC_STEP);
  assign cnt_inc    = cnt_q + 8'd1;

  // NOTE: every _d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    z_d          = z_q;
    n_d          = n_q;
    flag_vld_d   = flag_vld_q;
    cond_d       = cond_q;
    pc_d         = pc_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    out_taken_d  = out_taken_q;
    out_target_d = out_target_q;
    out_err_d    = out_err_q;

    if (cmp_valid) begin
      r_d        = cmp_res;
      z_d        = cmp_z;
      n_d        = cmp_n;
      flag_vld_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (br_valid) begin
          cond_d = br_cond;
          pc_d   = br_pc;
          off_d  = br_off;
          if (br_cond == 3'b000 || br_cond == 3'b111 || flag_vld_q || cmp_valid) begin
            state_d      = S_OUT;
            out_taken_d  = res_taken;
            out_target_d = res_target;
            out_err_d    = 1'b0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 8'd0;
          end
        end
      end
      S_WAIT: begin
        if (cmp_valid) begin
          state_d      = S_OUT;
          out_taken_d  = res_taken;
          out_target_d = res_target;
          out_err_d    = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) begin
            state_d      = S_OUT;
            out_taken_d  = 1'b0;
            out_target_d = pc_q + PC_STEP;
            out_err_d    = 1'b1;
          end
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      r_q          <= 1'b0;
      z_q          <= 1'b0;
      n_q          <= 1'b0;
      flag_vld_q   <= 1'b0;
      cond_q       <= 3'b000;
      pc_q         <= '0;
      off_q        <= '0;
      cnt_q        <= 8'd0;
      out_taken_q  <= 1'b0;
      out_target_q <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      z_q          <= z_d;
      n_q          <= n_d;
      flag_vld_q   <= flag_vld_d;
      cond_q       <= cond_d;
      pc_q         <= pc_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
      out_taken_q  <= out_taken_d;
      out_target_q <= out_target_d;
      out_err_q    <= out_err_d;
    end
  end

  assign br_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_OUT);
  assign out_taken  = out_taken_q;
  assign out_target = out_target_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_rel_branch_resolve.sv
// Bench for rel_branch_resolve: directed scenarios plus randomized branches checked
// against a transaction-level model of flag availability, latency and target.
module tb_rel_branch_resolve;
  localparam int W  = 32;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst, cmp_valid, cmp_res, cmp_z, cmp_n;
  logic         br_valid, br_ready, out_valid, out_ready, out_taken, out_err;
  logic [2:0]   br_cond;
  logic [W-1:0] br_pc, br_off, out_target;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the flag register as seen from outside.
  logic m_vld, m_r, m_z, m_n;

  rel_branch_resolve #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmp_valid(cmp_valid), .cmp_res(cmp_res), .cmp_z(cmp_z),
    .cmp_n(cmp_n), .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
    .br_pc(br_pc), .br_off(br_off), .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_target(out_target), .out_err(out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic model_taken(input logic [2:0] c, input logic r, input logic z,
                                       input logic n);
    case (c)
      3'd0: return 1'b1;
      3'd1: return r == 1'b1;
      3'd2: return r == 1'b0;
      3'd3: return z == 1'b1;
      3'd4: return z == 1'b0;
      3'd5: return n == 1'b1;
      3'd6: return n == 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  // Expected latency (edges from accept to out_valid) and result for one branch.
  // delay: cycle offset of the cmp_valid pulse relative to the accept cycle, -1 for none.
  task automatic predict(input logic [2:0] c, input logic [W-1:0] pc, input logic [W-1:0] off,
                         input int delay, input logic cr, input logic cz, input logic cn,
                         output int lat, output logic tk, output logic [W-1:0] tgt,
                         output logic er);
    if (c == 3'd0 || c == 3'd7 || m_vld || delay == 0) begin
      lat = 1;
      er  = 1'b0;
      tk  = (delay == 0) ? model_taken(c, cr, cz, cn) : model_taken(c, m_r, m_z, m_n);
    end else if (delay >= 1 && delay <= TO) begin
      lat = delay + 1;
      er  = 1'b0;
      tk  = model_taken(c, cr, cz, cn);
    end else begin
      lat = TO + 1;
      er  = 1'b1;
      tk  = 1'b0;
    end
    tgt = tk ? pc + off : pc + 32'd4;
  endtask

  task automatic idle_inputs();
    cmp_valid = 0; cmp_res = 0; cmp_z = 0; cmp_n = 0;
    br_valid = 0; br_cond = 0; br_pc = 0; br_off = 0; out_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_vld = 0; m_r = 0; m_z = 0; m_n = 0;
  endtask

  task automatic load_flags(input logic r, input logic z, input logic n);
    cmp_valid = 1; cmp_res = r; cmp_z = z; cmp_n = n;
    @(posedge clk); #1;
    cmp_valid = 0;
    m_vld = 1; m_r = r; m_z = z; m_n = n;
  endtask

  // Presents one branch and steps until out_valid (bounded); pulses cmp_valid at 'delay'.
  task automatic drive_branch(input logic [2:0] c, input logic [W-1:0] pc,
                              input logic [W-1:0] off, input int delay, input logic cr,
                              input logic cz, input logic cn, output int lat,
                              output logic saw_ready);
    logic sent;
    sent = 0;
    saw_ready = 0;
    br_valid = 1; br_cond = c; br_pc = pc; br_off = off;
    if (delay == 0) begin
      cmp_valid = 1; cmp_res = cr; cmp_z = cz; cmp_n = cn; sent = 1;
    end
    @(posedge clk); #1;
    br_valid = 0; cmp_valid = 0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      if (br_ready) saw_ready = 1;
      if (lat == delay) begin
        cmp_valid = 1; cmp_res = cr; cmp_z = cz; cmp_n = cn; sent = 1;
      end
      @(posedge clk); #1;
      cmp_valid = 0;
      lat++;
    end
    if (sent) begin
      m_vld = 1; m_r = cr; m_z = cz; m_n = cn;
    end
  endtask

  task automatic release_out();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmp_valid = 1; cmp_res = 1; cmp_z = 1; cmp_n = 1; br_valid = 1; br_cond = 3'd0;
    br_pc = 32'h40; br_off = 32'h8; out_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b0;
    m_vld = 0; m_r = 0; m_z = 0; m_n = 0;
    n_checks++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL reset_br_ready: got %b want 1", br_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_taken !== 1'b0) begin n_fail++; $display("FAIL reset_out_taken: got %b want 0", out_taken); end
    n_checks++; if (out_target !== 32'h0) begin n_fail++; $display("FAIL reset_out_target: got %h want 0", out_target); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b want 0", out_err); end
  endtask

  task automatic test_flags_first();
    int lat; logic saw;
    do_reset();
    load_flags(1'b0, 1'b1, 1'b0);
    drive_branch(3'b011, 32'h100, 32'h20, -1, 0, 0, 0, lat, saw);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL z_lat: got %0d want 1", lat); end
    n_checks++; if (out_taken !== 1'b1) begin n_fail++; $display("FAIL z_taken: got %b want 1", out_taken); end
    n_checks++; if (out_target !== 32'h120) begin n_fail++; $display("FAIL z_target: got %h want 120", out_target); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL z_err: got %b want 0", out_err); end
    release_out();
    n_checks++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL z_back_idle: got %b want 1", br_ready); end
  endtask

  task automatic test_not_r();
    int lat; logic saw;
    load_flags(1'b1, 1'b0, 1'b0);
    drive_branch(3'b010, 32'h100, 32'h20, -1, 0, 0, 0, lat, saw);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL notr_lat: got %0d want 1", lat); end
    n_checks++; if (out_taken !== 1'b0) begin n_fail++; $display("FAIL notr_taken: got %b want 0", out_taken); end
    n_checks++; if (out_target !== 32'h104) begin n_fail++; $display("FAIL notr_target: got %h want 104", out_target); end
    release_out();
  endtask

  task automatic test_late_flags();
    int lat; logic saw;
    do_reset();
    drive_branch(3'b001, 32'h200, 32'h40, 3, 1, 0, 0, lat, saw);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL late_lat: got %0d want 4", lat); end
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL late_br_ready_low: got %b want 0", saw); end
    n_checks++; if (out_taken !== 1'b1) begin n_fail++; $display("FAIL late_taken: got %b want 1", out_taken); end
    n_checks++; if (out_target !== 32'h240) begin n_fail++; $display("FAIL late_target: got %h want 240", out_target); end
    release_out();
  endtask

  task automatic test_timeout();
    int lat; logic saw;
    do_reset();
    drive_branch(3'b101, 32'h300, 32'h10, -1, 0, 0, 0, lat, saw);
    n_checks++; if (lat !== TO + 1) begin n_fail++; $display("FAIL to_lat: got %0d want %0d", lat, TO + 1); end
    n_checks++; if (out_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", out_err); end
    n_checks++; if (out_taken !== 1'b0) begin n_fail++; $display("FAIL to_taken: got %b want 0", out_taken); end
    n_checks++; if (out_target !== 32'h304) begin n_fail++; $display("FAIL to_target: got %h want 304", out_target); end
    release_out();
    // Flags arriving on the very last WAIT cycle win over the timeout.
    do_reset();
    drive_branch(3'b011, 32'h500, 32'h30, TO, 0, 1, 0, lat, saw);
    n_checks++; if (lat !== TO + 1) begin n_fail++; $display("FAIL edge_lat: got %0d want %0d", lat, TO + 1); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL edge_err: got %b want 0", out_err); end
    n_checks++; if (out_target !== 32'h530) begin n_fail++; $display("FAIL edge_target: got %h want 530", out_target); end
    release_out();
  endtask

  task automatic test_wrap_hold();
    int lat; logic saw;
    do_reset();
    drive_branch(3'b000, 32'hFFFF_FFFC, 32'h8, -1, 0, 0, 0, lat, saw);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL wrap_lat: got %0d want 1", lat); end
    n_checks++; if (out_target !== 32'h4) begin n_fail++; $display("FAIL wrap_target: got %h want 4", out_target); end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        cmp_valid = 1; cmp_res = 1; cmp_z = 0; cmp_n = 1;
      end
      @(posedge clk); #1;
      cmp_valid = 0;
      n_checks++;
      if (out_valid !== 1'b1 || out_taken !== 1'b1 || out_target !== 32'h4 || out_err !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_%0d: got v=%b t=%b tgt=%h e=%b want v=1 t=1 tgt=4 e=0",
                 i, out_valid, out_taken, out_target, out_err);
      end
    end
    m_vld = 1; m_r = 1; m_z = 0; m_n = 1;
    out_ready = 1;
    br_valid = 1; br_cond = 3'b000; br_pc = 32'h700; br_off = 32'h4;
    n_checks++; if (br_ready !== 1'b0) begin n_fail++; $display("FAIL ready_cycle_br_ready: got %b want 0", br_ready); end
    @(posedge clk); #1;
    out_ready = 0; br_valid = 0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_ready_valid: got %b want 0", out_valid); end
    n_checks++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL post_ready_idle: got %b want 1", br_ready); end
    // Flags written during OUT must be visible to the next branch.
    drive_branch(3'b101, 32'h800, 32'h100, -1, 0, 0, 0, lat, saw);
    n_checks++; if (lat !== 1 || out_taken !== 1'b1 || out_target !== 32'h900) begin
      n_fail++;
      $display("FAIL out_flag_update: got lat=%0d t=%b tgt=%h want lat=1 t=1 tgt=900", lat, out_taken, out_target);
    end
    release_out();
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    br_valid = 1; br_cond = 3'b001; br_pc = 32'h900; br_off = 32'h10;
    @(posedge clk); #1;
    br_valid = 0;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (br_ready !== 1'b0) begin n_fail++; $display("FAIL wait_br_ready: got %b want 0", br_ready); end
    rst = 1; cmp_valid = 1; cmp_res = 1; cmp_z = 1; cmp_n = 1; br_valid = 1; br_cond = 3'b000;
    @(posedge clk); #1;
    rst = 0; cmp_valid = 0; br_valid = 0;
    m_vld = 0; m_r = 0; m_z = 0; m_n = 0;
    n_checks++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL rstwait_br_ready: got %b want 1", br_ready); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstwait_no_valid_%0d: got %b want 0", i, out_valid); end
      @(posedge clk); #1;
    end
    // With flag_vld cleared, a conditional branch must wait.
    br_valid = 1; br_cond = 3'b011; br_pc = 32'hA00; br_off = 32'h4;
    @(posedge clk); #1;
    br_valid = 0;
    n_checks++; if (out_valid !== 1'b0 || br_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstwait_flags_cleared: got v=%b rdy=%b want v=0 rdy=0", out_valid, br_ready);
    end
    do_reset();
  endtask

  task automatic test_random();
    int lat, exp_lat, delay; logic saw, exp_tk, exp_er;
    logic [W-1:0] pc, off, exp_tgt;
    logic [2:0] c;
    logic cr, cz, cn;
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 7) == 0) do_reset();
      if ($urandom_range(0, 3) == 0) load_flags(1'($urandom), 1'($urandom), 1'($urandom));
      c = 3'($urandom); pc = $urandom; off = $urandom;
      cr = 1'($urandom); cz = 1'($urandom); cn = 1'($urandom);
      delay = int'($urandom_range(0, 19)) - 1;
      predict(c, pc, off, delay, cr, cz, cn, exp_lat, exp_tk, exp_tgt, exp_er);
      n_checks++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_idle: got %b want 1", it, br_ready); end
      drive_branch(c, pc, off, delay, cr, cz, cn, lat, saw);
      n_checks++;
      if (lat !== exp_lat || out_valid !== 1'b1 || out_taken !== exp_tk ||
          out_target !== exp_tgt || out_err !== exp_er) begin
        n_fail++;
        $display("FAIL rnd%0d c=%0d d=%0d: got lat=%0d v=%b t=%b tgt=%h e=%b want lat=%0d v=1 t=%b tgt=%h e=%b",
                 it, c, delay, lat, out_valid, out_taken, out_target, out_err,
                 exp_lat, exp_tk, exp_tgt, exp_er);
      end
      release_out();
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    m_vld = 0; m_r = 0; m_z = 0; m_n = 0;
    test_reset();
    test_flags_first();
    test_not_r();
    test_late_flags();
    test_timeout();
    test_wrap_hold();
    test_reset_in_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rel_branch_resolve.md
REL_BRANCH_RESOLVE -- requirements
Module: rel_branch_resolve

Interface
REQ-001 The block SHALL be parameterised as: WIDTH, 32, operand/PC/offset width.
REQ-002 The block SHALL be parameterised as: TIMEOUT, 15, maximum cycles spent waiting for flags (1..255).
REQ-003 The block SHALL have the port: clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have the port: rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have the port: cmp_valid  input  1  comparator flags valid this cycle.
REQ-006 The block SHALL have the port: cmp_res  input  1  relational result (e.g. not_equal) from the comparator stage.
REQ-007 The block SHALL have the port: cmp_z  input  1  comparator zero flag.
REQ-008 The block SHALL have the port: cmp_n  input  1  comparator negative flag.
REQ-009 The block SHALL have the port: br_valid  input  1  branch request valid.
REQ-010 The block SHALL have the port: br_ready  output  1  branch request accepted when high with br_valid.
REQ-011 The block SHALL have the port: br_cond  input  3  condition code.
REQ-012 The block SHALL have the port: br_pc  input  WIDTH  PC of branch instruction.
REQ-013 The block SHALL have the port: br_off  input  WIDTH  signed byte offset.
REQ-014 The block SHALL have the port: out_valid  output  1  resolution valid.
REQ-015 The block SHALL have the port: out_ready  input  1  downstream fetch accepts resolution.
REQ-016 The block SHALL have the port: out_taken  output  1  branch taken.
REQ-017 The block SHALL have the port: out_target  output  WIDTH  next PC.
REQ-018 The block SHALL have the port: out_err  output  1  resolved by timeout, flags never arrived.

Function
REQ-019 The block SHALL hold a flag register {R,Z,N} plus flag_vld; any cmp_valid cycle loads cmp_res/cmp_z/cmp_n and sets flag_vld, in every state; flags are sticky until overwritten.
REQ-020 The block SHALL implement states IDLE, WAIT, OUT; br_ready SHALL equal (state==IDLE).
REQ-021 The block SHALL, on br_valid&&br_ready, capture br_cond, br_pc, br_off.
REQ-022 The block SHALL treat conditions as: 000 always, 001 R, 010 !R, 011 Z, 100 !Z, 101 N, 110 !N, 111 never.
REQ-023 The block SHALL, on accept, go to OUT if cond is 000/111, flag_vld=1, or cmp_valid=1 that cycle (same-cycle flags bypass the register and are used); otherwise to WAIT.
REQ-024 The block SHALL, in WAIT, go to OUT on the first cmp_valid cycle, using those flags.
REQ-025 The block SHALL count WAIT cycles in an 8-bit counter cleared on WAIT entry; after TIMEOUT cycles without cmp_valid it SHALL go to OUT with out_err=1, out_taken=0.
REQ-026 The block SHALL, on cmp_valid in the same cycle the counter reaches TIMEOUT, resolve normally (out_err=0).
REQ-027 The block SHALL register out_taken/out_target/out_err on entry to OUT; out_valid=1 exactly while in OUT; latency accept-to-out_valid is 1 cycle when flags are available.
REQ-028 The block SHALL compute out_target = br_pc + br_off when taken, else br_pc + 4, both modulo 2^WIDTH (wrap, no overflow flag).
REQ-029 The block SHALL hold all out_* stable in OUT until out_ready=1, then return to IDLE next cycle; no new request is accepted in the out_ready cycle.
REQ-030 The block SHALL NOT let cmp_valid during OUT alter held outputs (flag register still updates).

Reset
REQ-031 The block SHALL, when rst=1 at a clock edge, force state=IDLE, flag_vld=0, R=Z=N=0, counter=0, out_valid=0, out_taken=0, out_target=0, out_err=0; br_ready=1 the cycle after.
REQ-032 The block SHALL, on rst during WAIT or OUT, abandon the pending branch with no out_valid pulse; rst has priority over cmp_valid and br_valid.

Verification
REQ-033 The bench SHALL cover: after reset, cmp_valid with res=0,z=1,n=0, then branch cond=011 pc=0x100 off=0x20 -> out_valid next cycle, taken=1, target=0x120, err=0.
REQ-034 The bench SHALL cover: flags res=1,z=0, branch cond=010 pc=0x100 off=0x20 -> taken=0, target=0x104.
REQ-035 The bench SHALL cover: after reset, branch cond=001 with no flags, cmp_valid res=1 three cycles later -> out_valid the following cycle, taken=1; br_ready low throughout.
REQ-036 The bench SHALL cover: after reset, branch cond=101, no cmp_valid -> out_valid after TIMEOUT (15) WAIT cycles with err=1, taken=0, target=pc+4.
REQ-037 The bench SHALL cover: pc=0xFFFFFFFC off=0x8 cond=000 -> target=0x00000004; out_ready held low 5 cycles -> outputs stable, then IDLE.
REQ-038 The bench SHALL cover: rst asserted in WAIT -> no out_valid, flag_vld cleared, br_ready=1 next cycle.
